// File: rtl/calc_key_if.sv
// calc_key_if: scanner key input and calculator entry outputs bundled for calc_key_entry
interface calc_key_if #(parameter int NDIGITS = 3);
  localparam int W = 4 * NDIGITS;
  logic         btn_pressed;
  logic [3:0]   btn_code;
  logic         key_evt;
  logic [3:0]   key_code;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   op;
  logic         calc_valid;
  logic [W-1:0] display;
  logic [1:0]   state;
  modport master (
    output btn_pressed, btn_code,
    input  key_evt, key_code, operand_a, operand_b, op, calc_valid, display, state
  );
  modport slave (
    input  btn_pressed, btn_code,
    output key_evt, key_code, operand_a, operand_b, op, calc_valid, display, state
  );
endinterface

// File: rtl/calc_key_entry.sv
// calc_key_entry: debounces scanner keys and runs the BCD calculator entry state machine
module calc_key_entry #(
  parameter int NDIGITS  = 3,
  parameter int DEBOUNCE = 16
) (
  input logic clk,
  input logic reset,
  calc_key_if.slave bus
);
  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int NW = $clog2(NDIGITS + 1);
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_RES = 2'b10} state_t;
  logic          prev_pressed, armed, accept, key_evt;
  logic [3:0]    prev_code, key_code;
  logic [CW-1:0] hi_cnt, lo_cnt, hi_nxt, lo_nxt;
  state_t        st, st_n;
  logic [W-1:0]  a, a_n, b, b_n, disp, disp_n;
  logic [NW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [1:0]    op, op_n;
  logic          cv, cv_n, is_dig, is_op, is_clr, is_eq;
  // run lengths of identical high samples and of low samples, saturating at DEBOUNCE
  assign hi_nxt = !bus.btn_pressed ? '0 :
                  (prev_pressed && bus.btn_code == prev_code) ?
                  (hi_cnt == CW'(DEBOUNCE) ? hi_cnt : hi_cnt + CW'(1)) : CW'(1);
  assign lo_nxt = bus.btn_pressed ? '0 : (lo_cnt == CW'(DEBOUNCE) ? lo_cnt : lo_cnt + CW'(1));
  assign accept = armed && hi_nxt == CW'(DEBOUNCE) && bus.btn_code != 4'hF;
  // debouncer: reset leaves it disarmed so a key held through reset needs a clean release first
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pressed <= 1'b0;
      prev_code    <= '0;
      hi_cnt       <= '0;
      lo_cnt       <= '0;
      armed        <= 1'b0;
      key_evt      <= 1'b0;
      key_code     <= '0;
    end else begin
      prev_pressed <= bus.btn_pressed;
      prev_code    <= bus.btn_code;
      hi_cnt       <= hi_nxt;
      lo_cnt       <= lo_nxt;
      armed        <= accept ? 1'b0 : (lo_nxt == CW'(DEBOUNCE) ? 1'b1 : armed);
      key_evt      <= accept;
      key_code     <= accept ? bus.btn_code : key_code;
    end
  end
  assign is_dig = key_code <= 4'h9;
  assign is_op  = key_code inside {4'hA, 4'hB, 4'hC};
  assign is_clr = key_code == 4'hD;
  assign is_eq  = key_code == 4'hE;
  // entry FSM next state; op encoding is the key code offset from ADD (A->0, B->1, C->2)
  always_comb begin
    st_n    = st;
    a_n     = a;
    b_n     = b;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    op_n    = op;
    cv_n    = 1'b0;
    if (key_evt) begin
      if (is_clr) begin
        st_n    = S_A;
        a_n     = '0;
        b_n     = '0;
        cnt_a_n = '0;
        cnt_b_n = '0;
        op_n    = '0;
      end else begin
        case (st)
          S_A: begin
            if (is_dig) begin
              if (cnt_a < NW'(NDIGITS)) begin
                a_n     = {a[W-5:0], key_code};
                cnt_a_n = cnt_a + NW'(1);
              end
            end else if (is_op) begin
              op_n    = key_code[1:0] - 2'd2;
              b_n     = '0;
              cnt_b_n = '0;
              st_n    = S_B;
            end
          end
          S_B: begin
            if (is_dig) begin
              if (cnt_b < NW'(NDIGITS)) begin
                b_n     = {b[W-5:0], key_code};
                cnt_b_n = cnt_b + NW'(1);
              end
            end else if (is_op) begin
              op_n = cnt_b == '0 ? key_code[1:0] - 2'd2 : op;
            end else if (is_eq && cnt_b != '0) begin
              cv_n = 1'b1;
              st_n = S_RES;
            end
          end
          S_RES: begin
            if (is_dig) begin
              a_n     = W'(key_code);
              cnt_a_n = NW'(1);
              b_n     = '0;
              cnt_b_n = '0;
              st_n    = S_A;
            end else if (is_op) begin
              op_n    = key_code[1:0] - 2'd2;
              b_n     = '0;
              cnt_b_n = '0;
              st_n    = S_B;
            end else if (is_eq) begin
              cv_n = 1'b1;
            end
          end
          default: st_n = S_A;
        endcase
      end
    end
    disp_n = st_n == S_A ? a_n : st_n == S_B ? (cnt_b_n != '0 ? b_n : a_n) : b_n;
  end
  // entry FSM and operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_A;
      a     <= '0;
      b     <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      op    <= '0;
      cv    <= 1'b0;
      disp  <= '0;
    end else begin
      st    <= st_n;
      a     <= a_n;
      b     <= b_n;
      cnt_a <= cnt_a_n;
      cnt_b <= cnt_b_n;
      op    <= op_n;
      cv    <= cv_n;
      disp  <= disp_n;
    end
  end
  assign bus.key_evt    = key_evt;
  assign bus.key_code   = key_code;
  assign bus.operand_a  = a;
  assign bus.operand_b  = b;
  assign bus.op         = op;
  assign bus.calc_valid = cv;
  assign bus.display    = disp;
  assign bus.state      = st;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: directed checks of debounce, entry FSM, CLR and reset behaviour
module tb_calc_key_entry;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int evt_cnt = 0;
  int cv_cnt = 0;
  int evt_at = 0;
  calc_key_if #(.NDIGITS(3)) bus ();
  calc_key_entry #(.NDIGITS(3), .DEBOUNCE(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input logic p, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      evt_cnt += int'(bus.key_evt);
      cv_cnt  += int'(bus.calc_valid);
      bus.btn_pressed = p;
      bus.btn_code    = c;
    end
  endtask
  task automatic key(input logic [3:0] c);
    hold(1'b1, c, 6);
    hold(1'b0, 4'h0, 6);
  endtask
  initial begin
    bus.btn_pressed = 1'b0;
    bus.btn_code    = 4'h0;
    hold(1'b0, 4'h0, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_a", 32'(bus.operand_a), 32'h0);
    chk("rst_b", 32'(bus.operand_b), 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_out", {bus.key_evt, bus.calc_valid, bus.op, bus.key_code, bus.display}, 32'h0);
    hold(1'b0, 4'h0, 5);
    evt_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.key_evt) begin
        evt_cnt++;
        evt_at = i;
      end
      bus.btn_pressed = 1'b1;
      bus.btn_code    = 4'h7;
    end
    hold(1'b0, 4'h0, 6);
    chk("t1_evt_count", 32'(evt_cnt), 32'd1);
    chk("t1_evt_cycle", 32'(evt_at), 32'd5);
    chk("t1_a", 32'(bus.operand_a), 32'h007);
    chk("t1_disp", 32'(bus.display), 32'h007);
    key(4'hD);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    chk("t2_a_trunc", 32'(bus.operand_a), 32'h123);
    key(4'hA);
    chk("t2_state_b", 32'(bus.state), 32'd1);
    chk("t2_disp_a", 32'(bus.display), 32'h123);
    key(4'h5);
    cv_cnt = 0;
    key(4'hE);
    chk("t2_cv", 32'(cv_cnt), 32'd1);
    chk("t2_b", 32'(bus.operand_b), 32'h005);
    chk("t2_op", 32'(bus.op), 32'd0);
    chk("t2_state", 32'(bus.state), 32'd2);
    chk("t2_disp", 32'(bus.display), 32'h005);
    evt_cnt = 0;
    hold(1'b1, 4'h6, 2);
    hold(1'b0, 4'h6, 1);
    hold(1'b1, 4'h6, 6);
    hold(1'b0, 4'h0, 2);
    hold(1'b1, 4'h6, 4);
    hold(1'b0, 4'h0, 6);
    chk("t3_evt_count", 32'(evt_cnt), 32'd1);
    chk("t3_a", 32'(bus.operand_a), 32'h006);
    chk("t3_state", 32'(bus.state), 32'd0);
    evt_cnt = 0;
    hold(1'b1, 4'h3, 2);
    hold(1'b1, 4'h5, 6);
    hold(1'b0, 4'h0, 6);
    chk("t4_evt_count", 32'(evt_cnt), 32'd1);
    chk("t4_code", 32'(bus.key_code), 32'h5);
    chk("t4_a", 32'(bus.operand_a), 32'h065);
    evt_cnt = 0;
    key(4'hF);
    chk("t4_f_evt", 32'(evt_cnt), 32'd0);
    chk("t4_f_a", 32'(bus.operand_a), 32'h065);
    chk("t4_f_state", 32'(bus.state), 32'd0);
    key(4'hB);
    chk("t5_op_sub", 32'(bus.op), 32'd1);
    key(4'hC);
    chk("t5_op_mul", 32'(bus.op), 32'd2);
    cv_cnt = 0;
    key(4'hE);
    chk("t5_eq_nob_cv", 32'(cv_cnt), 32'd0);
    chk("t5_eq_nob_state", 32'(bus.state), 32'd1);
    key(4'h2);
    key(4'hE);
    chk("t5_cv1", 32'(cv_cnt), 32'd1);
    key(4'hE);
    chk("t5_cv2", 32'(cv_cnt), 32'd2);
    chk("t5_a", 32'(bus.operand_a), 32'h065);
    chk("t5_b", 32'(bus.operand_b), 32'h002);
    chk("t5_op", 32'(bus.op), 32'd2);
    chk("t5_state", 32'(bus.state), 32'd2);
    key(4'hD);
    key(4'h4); key(4'h2); key(4'hB); key(4'h9);
    chk("t6_a", 32'(bus.operand_a), 32'h042);
    chk("t6_b", 32'(bus.operand_b), 32'h009);
    chk("t6_op", 32'(bus.op), 32'd1);
    chk("t6_disp", 32'(bus.display), 32'h009);
    cv_cnt = 0;
    key(4'hD);
    chk("t6_clr_cv", 32'(cv_cnt), 32'd0);
    chk("t6_clr_vals", {bus.operand_a, bus.operand_b, bus.op, bus.state}, 32'h0);
    chk("t6_clr_disp", 32'(bus.display), 32'h0);
    evt_cnt = 0;
    hold(1'b1, 4'h8, 2);
    reset = 1'b1;
    hold(1'b1, 4'h8, 1);
    reset = 1'b0;
    hold(1'b1, 4'h8, 10);
    chk("t6_rst_held_evt", 32'(evt_cnt), 32'd0);
    chk("t6_rst_held_a", 32'(bus.operand_a), 32'h0);
    hold(1'b0, 4'h0, 6);
    key(4'h8);
    chk("t6_repress_evt", 32'(evt_cnt), 32'd1);
    chk("t6_repress_a", 32'(bus.operand_a), 32'h008);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
